// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin codes and session state for the vending front end
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } session_state_e;

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - 2-flop synchroniser, stability counter, rising-edge event
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  // The event is raised on the same edge the level flips, so it lands one cycle earlier
  // than an edge detector on level_q would.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        rise_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/coin_intake.sv
// rtl/coin_intake.sv - debounced coin/button intake with 4-entry coin FIFO and session timeout
module coin_intake
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_half_raw,
  input  logic       coin_one_raw,
  input  logic       star_raw,
  input  logic       straits_raw,
  input  logic       coin_ready,
  input  logic       dispense_done,
  output logic       coin_valid,
  output logic [1:0] coin_code,
  output logic       star_pb,
  output logic       straits_pb,
  output logic       reject,
  output logic [2:0] fifo_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic half_ev, one_ev, star_ev, straits_ev;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_half (
    .clk(clk), .rst(rst), .raw_i(coin_half_raw), .rise_o(half_ev));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
    .clk(clk), .rst(rst), .raw_i(coin_one_raw), .rise_o(one_ev));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_star (
    .clk(clk), .rst(rst), .raw_i(star_raw), .rise_o(star_ev));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_straits (
    .clk(clk), .rst(rst), .raw_i(straits_raw), .rise_o(straits_ev));

  logic [1:0]     mem_q [FIFO_DEPTH];
  logic [1:0]     wr_ptr_q, rd_ptr_q;
  logic [2:0]     count_q;
  session_state_e state_q;
  logic [TW-1:0]  tmr_q;
  logic           star_q, straits_q, reject_q;
  logic           pend_valid_q, pend_valid_d;
  logic [1:0]     pend_q, pend_d;

  logic       pop, space, push;
  logic       wr_req, tok_push, coin_acc, coin_drop;
  logic [1:0] wr_data;
  logic       coin_single, coin_both;
  logic [1:0] coin_val;

  assign coin_valid  = (count_q != 3'd0);
  assign coin_code   = coin_valid ? mem_q[rd_ptr_q] : COIN_NONE;
  assign pop         = coin_valid & coin_ready;
  assign space       = (count_q != 3'(FIFO_DEPTH)) | pop;
  assign coin_single = half_ev ^ one_ev;
  assign coin_both   = half_ev & one_ev;
  assign coin_val    = half_ev ? COIN_HALF : COIN_ONE;
  assign push        = wr_req & space;

  // The FIFO has a single write port: the abort token and a coin held back by it take
  // priority over a fresh coin event.
  always_comb begin
    wr_req       = 1'b0;
    wr_data      = COIN_NONE;
    tok_push     = 1'b0;
    coin_acc     = 1'b0;
    coin_drop    = 1'b0;
    pend_valid_d = 1'b0;
    pend_d       = pend_q;
    if (state_q == FLUSH) begin
      if (space) begin
        wr_req   = 1'b1;
        tok_push = 1'b1;
        if (coin_single) begin
          pend_valid_d = 1'b1;
          pend_d       = coin_val;
        end
      end else begin
        coin_drop = coin_single;
      end
    end else if (pend_valid_q) begin
      wr_req    = 1'b1;
      wr_data   = pend_q;
      coin_acc  = space;
      coin_drop = ~space | coin_single;
    end else begin
      wr_req    = coin_single;
      wr_data   = coin_val;
      coin_acc  = coin_single & space;
      coin_drop = coin_single & ~space;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= COIN_NONE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (pop && !push) count_q <= count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      star_q       <= 1'b0;
      straits_q    <= 1'b0;
      reject_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= COIN_NONE;
    end else begin
      reject_q     <= coin_both | coin_drop;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;

      case (state_q)
        IDLE: begin
          tmr_q <= '0;
          if (coin_acc) state_q <= COLLECT;
        end
        COLLECT: begin
          if (dispense_done) begin
            state_q <= IDLE;
            tmr_q   <= '0;
          end else if (coin_acc) begin
            tmr_q <= '0;
          end else if (tmr_q == TMR_LAST) begin
            state_q <= FLUSH;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        FLUSH: begin
          if (tok_push) begin
            tmr_q   <= '0;
            state_q <= pend_valid_d ? COLLECT : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          tmr_q   <= '0;
        end
      endcase

      if (dispense_done || tok_push) begin
        star_q    <= 1'b0;
        straits_q <= 1'b0;
      end else if (!star_q && !straits_q) begin
        if (star_ev)         star_q    <= 1'b1;
        else if (straits_ev) straits_q <= 1'b1;
      end
    end
  end

  assign star_pb    = star_q;
  assign straits_pb = straits_q;
  assign reject     = reject_q;
  assign fifo_count = count_q;

endmodule
